button_press_classifier: RTL and testbench

//  Consumes the clean level from the button debouncer and classifies each gesture.

---
 rtl/button_press_classifier.sv | 141 ++++++++++++++
 tb/tb_button_press_classifier.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into press/short/long/double pulses plus a held level.
// Optional auto-repeat while long-held is enabled by defining BTN_AUTOREPEAT_EN.
module button_press_classifier #(
    parameter int CNT_W         = 20,
    parameter int LONG_CYCLES   = 500000,
    parameter int GAP_CYCLES    = 150000,
    parameter int REPEAT_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_level,
    output logic press_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESSED   = 3'd1,
        S_LONG_HELD = 3'd2,
        S_WAIT_GAP  = 3'd3,
        S_SECOND    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              btn_q;
    logic              press_q, press_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              double_q, double_d;
    logic              held_q, held_d;
    logic              rise, fall;

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    // btn_q resets high so a button held through reset cannot produce a rise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            btn_q    <= 1'b1;
            press_q  <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            btn_q    <= btn_level;
            press_q  <= press_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (rise) state_d = S_PRESSED;
            end
            S_PRESSED: begin
                if (fall)                     state_d = S_WAIT_GAP;
                else if (timer_q == LONG_LAST) state_d = S_LONG_HELD;
                else                          timer_d = timer_q + 1'b1;
            end
            S_LONG_HELD: begin
                if (fall) state_d = S_IDLE;
            end
            S_WAIT_GAP: begin
                if (rise)                     state_d = S_SECOND;
                else if (timer_q == GAP_LAST) state_d = S_IDLE;
                else                          timer_d = timer_q + 1'b1;
            end
            S_SECOND: begin
                if (fall)                state_d = S_IDLE;
                else if (timer_q != '1)  timer_d = timer_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_comb begin
        press_d  = rise && (state_q == S_IDLE || state_q == S_WAIT_GAP);
        long_d   = (state_q == S_PRESSED) && !fall && (timer_q == LONG_LAST);
        short_d  = (state_q == S_WAIT_GAP) && !rise && (timer_q == GAP_LAST);
        double_d = (state_q == S_SECOND) && fall;
        held_d   = (state_d == S_PRESSED) || (state_d == S_LONG_HELD) || (state_d == S_SECOND);
    end

    assign press_pulse  = press_q;
    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign held         = held_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_timer_q, rep_timer_d;
    logic             repeat_q, repeat_d;

    // Repeat timer only runs while the long hold continues; anything else clears it
    always_comb begin
        rep_timer_d = '0;
        repeat_d    = 1'b0;
        if (state_q == S_LONG_HELD && !fall) begin
            if (rep_timer_q == REPEAT_LAST) repeat_d    = 1'b1;
            else                            rep_timer_d = rep_timer_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_timer_q <= '0;
            repeat_q    <= 1'b0;
        end else begin
            rep_timer_q <= rep_timer_d;
            repeat_q    <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Self-checking bench for button_press_classifier: directed gesture scenarios plus
// randomized level streams, checked against a timestamp-based gesture model.
module tb_button_press_classifier;

    localparam int CNT_W  = 8;
    localparam int LONG_C = 8;
    localparam int GAP_C  = 6;
    localparam int REP_C  = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic btn_level;
    logic press_pulse, short_press, long_press, double_press, repeat_pulse, held;

    int checks = 0;
    int errors = 0;

    button_press_classifier #(
        .CNT_W(CNT_W),
        .LONG_CYCLES(LONG_C),
        .GAP_CYCLES(GAP_C),
        .REPEAT_CYCLES(REP_C)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_level(btn_level),
        .press_pulse(press_pulse),
        .short_press(short_press),
        .long_press(long_press),
        .double_press(double_press),
        .repeat_pulse(repeat_pulse),
        .held(held)
    );

    always #5 clock = ~clock;

    wire [5:0] dut_vec = {press_pulse, short_press, long_press, double_press, repeat_pulse, held};

    // Reference model: gesture phases tracked by the cycle numbers of press,
    // release and long detection rather than by counters.
    localparam int M_IDLE = 0, M_DOWN = 1, M_LONG = 2, M_GAP = 3, M_SECOND = 4;
    int   mode, n, t_press, t_rel, t_long;
    logic prev;
    logic [5:0] exp_vec;

    always @(posedge clock or posedge reset) begin
        logic r, f, p, s, l, d, rp;
        if (reset) begin
            mode    = M_IDLE;
            prev    = 1'b1;
            exp_vec = '0;
        end else begin
            n  = n + 1;
            r  = btn_level & ~prev;
            f  = ~btn_level & prev;
            p  = 0; s = 0; l = 0; d = 0; rp = 0;
            case (mode)
                M_IDLE:   if (r) begin mode = M_DOWN; t_press = n; p = 1; end
                M_DOWN:   if (f) begin mode = M_GAP; t_rel = n; end
                          else if (n - t_press == LONG_C) begin mode = M_LONG; t_long = n; l = 1; end
                M_LONG:   if (f) mode = M_IDLE;
                          else if (AUTOREP && ((n - t_long) % REP_C == 0)) rp = 1;
                M_GAP:    if (r) begin mode = M_SECOND; p = 1; end
                          else if (n - t_rel == GAP_C) begin mode = M_IDLE; s = 1; end
                M_SECOND: if (f) begin mode = M_IDLE; d = 1; end
                default:  mode = M_IDLE;
            endcase
            exp_vec = {p, s, l, d, rp, (mode == M_DOWN || mode == M_LONG || mode == M_SECOND)};
            prev = btn_level;
        end
    end

    // Drive a level for one cycle; returns #1 after the capturing edge.
    task automatic drive(input logic lvl);
        @(negedge clock);
        btn_level = lvl;
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) drive(1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn_level = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=%b", dut_vec, 6'b0);
        end
        @(negedge clock);
        reset = 1'b0;
        settle();
    endtask

    task automatic test_short();
        int np = 0, ns = 0, nl = 0, nd = 0, ts = -1;
        for (int i = 0; i < 14; i++) begin
            drive(i < 3);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL short_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec);
            end
            np += press_pulse; ns += short_press; nl += long_press; nd += double_press;
            if (short_press) ts = i;
        end
        checks++;
        if ({np, ns, nl, nd} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL short_counts got=p%0d s%0d l%0d d%0d want=p1 s1 l0 d0", np, ns, nl, nd);
        end
        checks++;
        if (ts !== 3 + GAP_C) begin
            errors++;
            $display("FAIL short_latency got=%0d want=%0d", ts, 3 + GAP_C);
        end
        settle();
    endtask

    task automatic test_long();
        int nl = 0, nr = 0, tl = -1, nbad = 0;
        int rep_at[$];
        for (int i = 0; i < 26; i++) begin
            drive(i <= 20);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL long_model cyc=%0d got=%b want=%b", i, dut_vec, exp_vec);
            end
            if (i <= 20 && !held) nbad++;
            if (i > 20 && (held || short_press || double_press)) nbad++;
            nl += long_press;
            if (long_press) tl = i;
            if (repeat_pulse) begin nr++; rep_at.push_back(i); end
        end
        checks++;
        if (nl !== 1 || tl !== LONG_C) begin
            errors++;
            $display("FAIL long_timing got=n%0d at%0d want=n1 at%0d", nl, tl, LONG_C);
        end
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL long_held_level got=%0d bad cycles want=0", nbad);
        end
        checks++;
        if (nr !== (AUTOREP ? 3 : 0) || (AUTOREP && rep_at.size() == 3 &&
            (rep_at[0] != LONG_C + 4 || rep_at[1] != LONG_C + 8 || rep_at[2] != LONG_C + 12))) begin
            errors++;
            $display("FAIL long_repeat got=%0d pulses want=%0d", nr, AUTOREP ? 3 : 0);
        end
        settle();
    endtask

    task automatic run_double(input int hold1, input int gap, input string name);
        int np = 0, ns = 0, nl = 0, nd = 0, len;
        len = hold1 + gap + 2 + 10;
        for (int i = 0; i < len; i++) begin
            drive((i < hold1) || (i >= hold1 + gap && i < hold1 + gap + 2));
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL %s_model cyc=%0d got=%b want=%b", name, i, dut_vec, exp_vec);
            end
            np += press_pulse; ns += short_press; nl += long_press; nd += double_press;
        end
        checks++;
        if ({np, ns, nl, nd} !== {32'd2, 32'd0, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL %s_counts got=p%0d s%0d l%0d d%0d want=p2 s0 l0 d1", name, np, ns, nl, nd);
        end
        settle();
    endtask

    task automatic test_double();
        run_double(2, 3, "double");
    endtask

    // Release lands on the long-detect edge and re-press on the short-detect edge.
    task automatic test_boundary();
        run_double(LONG_C, GAP_C, "boundary");
    endtask

    task automatic test_reset_held();
        int np = 0;
        @(negedge clock);
        reset = 1'b1;
        btn_level = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1);
            np += press_pulse;
        end
        checks++;
        if (np !== 0) begin
            errors++;
            $display("FAIL reset_held_press got=%0d want=0", np);
        end
        drive(1'b0);
        drive(1'b1);
        checks++;
        if (press_pulse !== 1'b1) begin
            errors++;
            $display("FAIL repress_after_reset got=%b want=1", press_pulse);
        end
        drive(1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_press got=%b want=%b", dut_vec, 6'b0);
        end
        @(posedge clock);
        #1;
        checks++;
        if (dut_vec !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid_press_next got=%b want=%b", dut_vec, 6'b0);
        end
        @(negedge clock);
        reset = 1'b0;
        btn_level = 1'b0;
        settle();
    endtask

    task automatic test_random();
        int multi = 0;
        for (int run = 0; run < 150; run++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                drive(lvl);
                checks++;
                if (dut_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL random_model run=%0d got=%b want=%b", run, dut_vec, exp_vec);
                end
                if (int'(short_press) + int'(long_press) + int'(double_press) > 1) multi++;
            end
        end
        checks++;
        if (multi !== 0) begin
            errors++;
            $display("FAIL exclusive_events got=%0d want=0", multi);
        end
        settle();
    endtask

    initial begin
        n = 0;
        test_reset();
        test_short();
        test_long();
        test_double();
        test_boundary();
        test_reset_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
